// File: rtl/d_stage.sv
// d_stage -- IF/ID pipeline register plus decode-stage branch support.
//
// Holds the fetched instruction and its PC (the only storage in the block)
// and derives, combinationally, everything the decode stage needs to
// resolve control transfers early: register fields, immediate fields,
// the jump class, forwarded rs/rt values and their equality flag.
//
// Ports:
//   clk                     clock, rising edge
//   reset                   synchronous active-high reset (overrides enable)
//   enable                  1 = load IF/ID register, 0 = hold (stall)
//   F_instr, F_pc           instruction and PC from the fetch stage
//   rsData, rtData          register-file read data for D_rs / D_rt
//   E_fwd*, M_fwd*          forwarding sources; E has priority over M
//   D_instr, D_pc           registered instruction and PC
//   D_pcPlus4               D_pc + 4 (wraps modulo 2^32)
//   D_rs, D_rt              instruction register fields
//   jumpOp                  0 none, 1 beq, 2 jal, 3 jr
//   zero                    forwarded rs == forwarded rt (any instruction)
//   offset, instr_index     immediate fields of D_instr
//   rsIn                    forwarded rs value (jr target)
module d_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] F_instr,
  input  logic [31:0] F_pc,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  input  logic        E_fwdValid,
  input  logic [4:0]  E_fwdAddr,
  input  logic [31:0] E_fwdData,
  input  logic        M_fwdValid,
  input  logic [4:0]  M_fwdAddr,
  input  logic [31:0] M_fwdData,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pcPlus4,
  output logic [4:0]  D_rs,
  output logic [4:0]  D_rt,
  output logic [2:0]  jumpOp,
  output logic        zero,
  output logic [15:0] offset,
  output logic [25:0] instr_index,
  output logic [31:0] rsIn
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;

  localparam logic [2:0] JOP_NONE = 3'd0;
  localparam logic [2:0] JOP_BEQ  = 3'd1;
  localparam logic [2:0] JOP_JAL  = 3'd2;
  localparam logic [2:0] JOP_JR   = 3'd3;

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // IF/ID register: reset wins over a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= 32'h0000_0000;
      r_pc    <= RESET_PC;
    end else if (enable) begin
      r_instr <= F_instr;
      r_pc    <= F_pc;
    end
  end

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = r_instr[31:26];
  assign w_funct  = r_instr[5:0];

  assign D_instr     = r_instr;
  assign D_pc        = r_pc;
  assign D_pcPlus4   = r_pc + 32'd4;
  assign D_rs        = r_instr[25:21];
  assign D_rt        = r_instr[20:16];
  assign offset      = r_instr[15:0];
  assign instr_index = r_instr[25:0];

  always_comb begin
    jumpOp = JOP_NONE;
    if (w_opcode == OP_BEQ) begin
      jumpOp = JOP_BEQ;
    end else if (w_opcode == OP_JAL) begin
      jumpOp = JOP_JAL;
    end else if (w_opcode == OP_SPECIAL && w_funct == FN_JR) begin
      jumpOp = JOP_JR;
    end
  end

  // Operand 0 is rs, operand 1 is rt; both use the same forwarding mux.
  logic [4:0]  w_addr [2];
  logic [31:0] w_gpr  [2];
  logic [31:0] w_fwd  [2];

  assign w_addr[0] = r_instr[25:21];
  assign w_addr[1] = r_instr[20:16];
  assign w_gpr[0]  = rsData;
  assign w_gpr[1]  = rtData;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_fwd
      // $0 is hardwired; testing the operand address first also makes a
      // source that targets $0 impossible to select.
      always_comb begin
        w_fwd[gi] = w_gpr[gi];
        if (w_addr[gi] == 5'd0) begin
          w_fwd[gi] = 32'h0000_0000;
        end else if (E_fwdValid && E_fwdAddr == w_addr[gi]) begin
          w_fwd[gi] = E_fwdData;
        end else if (M_fwdValid && M_fwdAddr == w_addr[gi]) begin
          w_fwd[gi] = M_fwdData;
        end
      end
    end
  endgenerate

  assign rsIn = w_fwd[0];
  assign zero = (w_fwd[0] == w_fwd[1]);

endmodule

// File: tb/tb_d_stage.sv
module tb_d_stage;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        E_fwdValid;
  logic [4:0]  E_fwdAddr;
  logic [31:0] E_fwdData;
  logic        M_fwdValid;
  logic [4:0]  M_fwdAddr;
  logic [31:0] M_fwdData;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pcPlus4;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [2:0]  jumpOp;
  logic        zero;
  logic [15:0] offset;
  logic [25:0] instr_index;
  logic [31:0] rsIn;

  d_stage dut (
    .clk(clk), .reset(reset), .enable(enable),
    .F_instr(F_instr), .F_pc(F_pc),
    .rsData(rsData), .rtData(rtData),
    .E_fwdValid(E_fwdValid), .E_fwdAddr(E_fwdAddr), .E_fwdData(E_fwdData),
    .M_fwdValid(M_fwdValid), .M_fwdAddr(M_fwdAddr), .M_fwdData(M_fwdData),
    .D_instr(D_instr), .D_pc(D_pc), .D_pcPlus4(D_pcPlus4),
    .D_rs(D_rs), .D_rt(D_rt), .jumpOp(jumpOp), .zero(zero),
    .offset(offset), .instr_index(instr_index), .rsIn(rsIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        ev;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [31:0] x_instr;
    logic [31:0] x_pc;
    logic [31:0] x_pc4;
    logic [2:0]  x_jop;
    logic [31:0] x_rsin;
    logic        x_zero;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic en, input logic [31:0] instr, input logic [31:0] pc,
    input logic [31:0] rs_d, input logic [31:0] rt_d,
    input logic ev, input logic [4:0] ea, input logic [31:0] ed,
    input logic mv, input logic [4:0] ma, input logic [31:0] md,
    input logic [31:0] x_instr, input logic [31:0] x_pc, input logic [31:0] x_pc4,
    input logic [2:0] x_jop, input logic [31:0] x_rsin, input logic x_zero);
    vec_t v;
    v.rst = rst; v.en = en; v.instr = instr; v.pc = pc;
    v.rs_d = rs_d; v.rt_d = rt_d;
    v.ev = ev; v.ea = ea; v.ed = ed; v.mv = mv; v.ma = ma; v.md = md;
    v.x_instr = x_instr; v.x_pc = x_pc; v.x_pc4 = x_pc4;
    v.x_jop = x_jop; v.x_rsin = x_rsin; v.x_zero = x_zero;
    return v;
  endfunction

  // Reference model: spec-level decode and forwarding rules.
  function automatic logic [2:0] ref_jop(input logic [31:0] ins);
    if (ins[31:26] == 6'd4) return 3'd1;
    if (ins[31:26] == 6'd3) return 3'd2;
    if (ins[31:26] == 6'd0 && ins[5:0] == 6'd8) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] gpr);
    if (a == 0) return 32'd0;
    if (E_fwdValid && E_fwdAddr == a) return E_fwdData;
    if (M_fwdValid && M_fwdAddr == a) return M_fwdData;
    return gpr;
  endfunction

  task automatic check_all(input string tag, input logic [31:0] xi, input logic [31:0] xp,
                           input logic [31:0] xp4, input logic [2:0] xj,
                           input logic [31:0] xrs, input logic xz);
    chk({tag, ".D_instr"}, D_instr, xi);
    chk({tag, ".D_pc"}, D_pc, xp);
    chk({tag, ".D_pcPlus4"}, D_pcPlus4, xp4);
    chk({tag, ".D_rs"}, {27'd0, D_rs}, {27'd0, xi[25:21]});
    chk({tag, ".D_rt"}, {27'd0, D_rt}, {27'd0, xi[20:16]});
    chk({tag, ".offset"}, {16'd0, offset}, {16'd0, xi[15:0]});
    chk({tag, ".instr_index"}, {6'd0, instr_index}, {6'd0, xi[25:0]});
    chk({tag, ".jumpOp"}, {29'd0, jumpOp}, {29'd0, xj});
    chk({tag, ".rsIn"}, rsIn, xrs);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, xz});
  endtask

  logic [31:0] m_instr, m_pc, x_rs, x_rt, kinds;

  initial begin
    reset = 0; enable = 0; F_instr = 0; F_pc = 0; rsData = 0; rtData = 0;
    E_fwdValid = 0; E_fwdAddr = 0; E_fwdData = 0;
    M_fwdValid = 0; M_fwdAddr = 0; M_fwdData = 0;

    //        rst en  instr         pc            rsD     rtD    ev ea  ed          mv ma  md           x_instr       x_pc          x_pc4         jop rsIn        zero
    vecs.push_back(mk(1, 0, 32'hDEADBEEF, 32'h00001234, 32'd1, 32'd2, 0, 0, 32'd0, 0, 0, 32'd0, 32'h00000000, 32'h00003000, 32'h00003004, 0, 32'd0, 1));
    vecs.push_back(mk(0, 1, 32'h10220003, 32'h00003000, 32'd5, 32'd7, 1, 2, 32'd5, 0, 0, 32'd0, 32'h10220003, 32'h00003000, 32'h00003004, 1, 32'd5, 1));
    vecs.push_back(mk(0, 1, 32'h00600008, 32'h00003004, 32'h1111, 32'd7, 1, 3, 32'h3010, 1, 3, 32'h3020, 32'h00600008, 32'h00003004, 32'h00003008, 3, 32'h3010, 0));
    vecs.push_back(mk(0, 1, 32'h0C000C10, 32'h00003008, 32'd9, 32'd9, 0, 0, 32'd0, 0, 0, 32'd0, 32'h0C000C10, 32'h00003008, 32'h0000300C, 2, 32'd0, 1));
    vecs.push_back(mk(0, 0, 32'h10220003, 32'h00004000, 32'd1, 32'd2, 0, 0, 32'd0, 0, 0, 32'd0, 32'h0C000C10, 32'h00003008, 32'h0000300C, 2, 32'd0, 1));
    vecs.push_back(mk(0, 0, 32'h00600008, 32'h00005000, 32'd1, 32'd2, 0, 0, 32'd0, 0, 0, 32'd0, 32'h0C000C10, 32'h00003008, 32'h0000300C, 2, 32'd0, 1));
    vecs.push_back(mk(0, 0, 32'hFFFFFFFF, 32'h00006000, 32'd1, 32'd2, 0, 0, 32'd0, 0, 0, 32'd0, 32'h0C000C10, 32'h00003008, 32'h0000300C, 2, 32'd0, 1));
    vecs.push_back(mk(0, 1, 32'h10000000, 32'h0000300C, 32'd3, 32'd4, 1, 0, 32'd9, 0, 0, 32'd0, 32'h10000000, 32'h0000300C, 32'h00003010, 1, 32'd0, 1));
    vecs.push_back(mk(0, 1, 32'h00430820, 32'h00003010, 32'hAB, 32'h55, 0, 3, 32'd1, 1, 3, 32'hAB, 32'h00430820, 32'h00003010, 32'h00003014, 0, 32'hAB, 1));
    vecs.push_back(mk(0, 1, 32'h00000000, 32'hFFFFFFFC, 32'd1, 32'd2, 0, 0, 32'd0, 0, 0, 32'd0, 32'h00000000, 32'hFFFFFFFC, 32'h00000000, 0, 32'd0, 1));
    vecs.push_back(mk(1, 0, 32'h00600008, 32'h00007000, 32'd1, 32'd2, 0, 0, 32'd0, 0, 0, 32'd0, 32'h00000000, 32'h00003000, 32'h00003004, 0, 32'd0, 1));
    vecs.push_back(mk(0, 1, 32'h00220008, 32'h00003000, 32'h10, 32'h20, 1, 2, 32'h10, 1, 1, 32'h99, 32'h00220008, 32'h00003000, 32'h00003004, 3, 32'h99, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; enable = vecs[i].en;
      F_instr = vecs[i].instr; F_pc = vecs[i].pc;
      rsData = vecs[i].rs_d; rtData = vecs[i].rt_d;
      E_fwdValid = vecs[i].ev; E_fwdAddr = vecs[i].ea; E_fwdData = vecs[i].ed;
      M_fwdValid = vecs[i].mv; M_fwdAddr = vecs[i].ma; M_fwdData = vecs[i].md;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].x_instr, vecs[i].x_pc, vecs[i].x_pc4,
                vecs[i].x_jop, vecs[i].x_rsin, vecs[i].x_zero);
      $display("vec%0d: instr=%08h pc=%08h jumpOp=%0d rsIn=%08h zero=%0b",
               i, D_instr, D_pc, jumpOp, rsIn, zero);
    end

    // Randomized phase against the reference model.
    m_instr = 32'h0000_0000;
    m_pc    = 32'h0000_3000;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 15) == 0);
      enable = ($urandom_range(0, 3) != 0);
      kinds  = $urandom_range(0, 4);
      F_instr = $urandom;
      F_instr[25:21] = 5'($urandom_range(0, 3));
      F_instr[20:16] = 5'($urandom_range(0, 3));
      case (kinds)
        0: F_instr[31:26] = 6'd4;
        1: F_instr[31:26] = 6'd3;
        2: begin F_instr[31:26] = 6'd0; F_instr[5:0] = 6'd8; end
        3: F_instr[31:26] = 6'd0;
        default: ;
      endcase
      F_pc = {$urandom, 2'b00} >> 0;
      rsData = $urandom_range(0, 3); rtData = $urandom_range(0, 3);
      E_fwdValid = 1'($urandom); E_fwdAddr = 5'($urandom_range(0, 3)); E_fwdData = $urandom_range(0, 3);
      M_fwdValid = 1'($urandom); M_fwdAddr = 5'($urandom_range(0, 3)); M_fwdData = $urandom_range(0, 3);
      if (reset) begin
        m_instr = 32'h0000_0000; m_pc = 32'h0000_3000;
      end else if (enable) begin
        m_instr = F_instr; m_pc = F_pc;
      end
      @(posedge clk);
      #1;
      x_rs = ref_fwd(m_instr[25:21], rsData);
      x_rt = ref_fwd(m_instr[20:16], rtData);
      check_all($sformatf("rnd%0d", c), m_instr, m_pc, m_pc + 32'd4,
                ref_jop(m_instr), x_rs, (x_rs == x_rt));
      $display("rnd%0d: rst=%0b en=%0b instr=%08h pc=%08h jumpOp=%0d rsIn=%08h zero=%0b",
               c, reset, enable, D_instr, D_pc, jumpOp, rsIn, zero);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/d_stage.md
D_STAGE -- requirements
Module: d_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port enable, input, 1 bit: 1 loads the IF/ID register; 0 holds it (stall).
REQ-004 SHALL have port F_instr, input, 32 bits: the instruction fetched in the F stage.
REQ-005 SHALL have port F_pc, input, 32 bits: the PC of F_instr.
REQ-006 SHALL have ports rsData and rtData, input, 32 bits each: GRF read data for D_rs and D_rt.
REQ-007 SHALL have ports E_fwdValid (1 bit), E_fwdAddr (5 bits) and E_fwdData (32 bits), input: the E-stage forwarding source.
REQ-008 SHALL have ports M_fwdValid (1 bit), M_fwdAddr (5 bits) and M_fwdData (32 bits), input: the M-stage forwarding source.
REQ-009 SHALL have port D_instr, output, 32 bits: the registered instruction.
REQ-010 SHALL have port D_pc, output, 32 bits: the registered PC.
REQ-011 SHALL have port D_pcPlus4, output, 32 bits: D_pc + 4, modulo 2^32.
REQ-012 SHALL have ports D_rs and D_rt, output, 5 bits each: D_instr[25:21] and D_instr[20:16].
REQ-013 SHALL have port jumpOp, output, 3 bits: 0 = none, 1 = beq, 2 = jal, 3 = jr; values 4-7 are never driven.
REQ-014 SHALL have port zero, output, 1 bit: 1 when the forwarded rs value equals the forwarded rt value.
REQ-015 SHALL have ports offset (16 bits, D_instr[15:0]) and instr_index (26 bits, D_instr[25:0]), output.
REQ-016 SHALL have port rsIn, output, 32 bits: the forwarded rs value, used as the jr target.

Function
REQ-017 SHALL, on a rising edge with reset=0 and enable=1, load D_instr <= F_instr and D_pc <= F_pc.
REQ-018 SHALL, on a rising edge with reset=0 and enable=0, hold D_instr and D_pc unchanged, whatever the other inputs are.
REQ-019 SHALL decode jumpOp combinationally from D_instr:
- opcode 000100 -> 1 (beq)
- opcode 000011 -> 2 (jal)
- opcode 000000 with funct 001000 -> 3 (jr)
- anything else, including 0x00000000 -> 0
REQ-020 SHALL forward rs combinationally, in this priority order:
- D_rs == 0 -> 0
- E_fwdValid and E_fwdAddr == D_rs -> E_fwdData
- M_fwdValid and M_fwdAddr == D_rs -> M_fwdData
- otherwise -> rsData
REQ-021 SHALL forward rt by the same rule as REQ-020, using D_rt and rtData.
REQ-022 SHALL ignore a forwarding source whose address is 0, even when its valid bit is 1.
REQ-023 SHALL compute zero from the full 32-bit forwarded values, and compute it for every instruction, not only beq.
REQ-024 SHALL give every output zero-cycle combinational latency from the registered state and the forwarding inputs; the only storage is D_instr and D_pc.
REQ-025 SHALL NOT flush on a taken branch or jump: the delay-slot instruction is loaded normally.
REQ-026 SHALL let D_pcPlus4 wrap: D_pc = 0xFFFFFFFC gives D_pcPlus4 = 0x00000000.

Reset
REQ-027 SHALL, on a rising edge with reset=1, set D_instr = 0x00000000 and D_pc = 0x00003000, regardless of enable.
REQ-028 SHALL therefore reset outputs to: jumpOp = 0, D_pcPlus4 = 0x00003004, D_rs = D_rt = 0, offset = 0, instr_index = 0, rsIn = 0, zero = 1.
REQ-029 SHALL let reset override a stall: reset=1 with enable=0 still clears the register.

Verification
REQ-030 SHALL pass this reset case: reset=1 for one edge with enable=0 -> D_pc = 0x00003000, D_instr = 0, jumpOp = 0, zero = 1.
REQ-031 SHALL pass this beq-with-forwarding case:
- stimulus: load F_instr = 0x10220003 (beq $1,$2), rsData = 5, rtData = 7, then drive E_fwdValid = 1, E_fwdAddr = 2, E_fwdData = 5
- response: jumpOp = 1, offset = 0x0003, zero = 1.
REQ-032 SHALL pass this priority case: jr $3 (0x00600008) with E_fwdAddr = 3 (data 0x3010) and M_fwdAddr = 3 (data 0x3020), both valid -> jumpOp = 3, rsIn = 0x3010.
REQ-033 SHALL pass this stall case: load jal 0x0C000C10 at F_pc = 0x3008, then enable = 0 for 3 edges while F_instr changes -> D_instr, D_pc and jumpOp = 2 stay stable, D_pcPlus4 = 0x300C, instr_index = 0x0000C10.
REQ-034 SHALL pass this $0 case: beq $0,$0 with E_fwdValid = 1, E_fwdAddr = 0, E_fwdData = 9 -> rsIn = 0, zero = 1.
REQ-035 SHALL pass this wrap case: F_pc = 0xFFFFFFFC loaded -> D_pcPlus4 = 0x00000000.
